ntt_addr_gen: RTL
=================

NTT_ADDR_GEN -- requirements
Module: ntt_addr_gen

Interface
REQ-001 Parameter WB_LAT, default 6: cycles from rd_en to the matching wr_en (1 bank read cycle plus PE latency); legal range 2..15.
REQ-002 clk  input  1  single clock; all flops rising-edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  one-cycle request to run one full transform.
REQ-005 KD_mode  input  1  0 = Kyber (128 words, 7 stages); 1 = Dilithium (256 words, 8 stages).
REQ-006 inv  input  1  0 = forward NTT; 1 = inverse NTT.
REQ-007 busy  output  1  high from the cycle after an accepted start until done.
REQ-008 done  output  1  one-cycle pulse at the end of the transform.
REQ-009 rd_en  output  1  bank read strobe, one butterfly pair per cycle.
REQ-010 rd_addr_a, rd_addr_b  output  8  top and bottom operand word addresses.
REQ-011 tw_addr  output  9  twiddle ROM address; bit 8 = inv.
REQ-012 wr_en  output  1  bank write strobe.
REQ-013 wr_addr_a, wr_addr_b  output  8  writeback addresses.
REQ-014 pe_KD_mode, pe_sel_1  output  1 each  latched KD_mode and inv, driven to the PE.
REQ-015 stage  output  4  index of the current stage.

Function
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, DRAIN, DONE.
REQ-017 In IDLE, start SHALL latch KD_mode and inv, set stage = 0 and the pair counter to 0, and move to ISSUE.
REQ-018 start SHALL be ignored in every state other than IDLE.
REQ-019 A mode-input change while busy SHALL have no effect.
REQ-020 rd_en SHALL be high on every ISSUE cycle, one pair per cycle; the first rd_en SHALL occur in the cycle after start.
REQ-021 Each stage SHALL issue NW/2 pairs, where NW = 128 for Kyber and 256 for Dilithium.
REQ-022 Forward, stage s: len = NW>>(s+1).
REQ-023 Inverse, stage s: len = 1<<s.
REQ-024 Pair p: group g = p / len, j = p mod len; rd_addr_a = 2*len*g + j and rd_addr_b = rd_addr_a + len.
REQ-025 tw_addr low 8 bits: forward = (1<<s) + g; inverse = (1<<(L-1-s)) + g, where L is the stage count.
REQ-026 After the last pair of a stage, the FSM SHALL move to DRAIN for exactly WB_LAT cycles with rd_en low (RAW hazard barrier).
REQ-027 On leaving DRAIN, the FSM SHALL increment stage and return to ISSUE, or go to DONE after stage L-1.
REQ-028 DONE SHALL last one cycle with done = 1, then return to IDLE; busy SHALL be low in the DONE cycle.
REQ-029 wr_en, wr_addr_a and wr_addr_b SHALL equal rd_en, rd_addr_a and rd_addr_b delayed by exactly WB_LAT cycles.
REQ-030 As a consequence of REQ-026 and REQ-029, the last write of a stage SHALL coincide with the last DRAIN cycle.
REQ-031 All outputs SHALL be registered, and the address/control outputs SHALL be zero whenever rd_en or wr_en is low.
REQ-032 Total latency from start to done SHALL be 1 + L*(NW/2 + WB_LAT) cycles.

Reset
REQ-033 Asserting rst at any time, including mid-transform, SHALL force IDLE and clear every output and the delay line to 0; pending writes SHALL be discarded.
REQ-034 The first start after rst deasserts SHALL be accepted normally.

Structure
REQ-035 A shared package ntt_pkg SHALL hold NW_K=128, NW_D=256, L_K=7, L_D=8 and the state enum.
REQ-036 The writeback delay line SHALL be a sub-module wb_delay (parameterised width and depth), instantiated once for {en, addr_a, addr_b}.
REQ-037 The address arithmetic SHALL use shifts and masks only, with no dividers.

Verification
REQ-038 Kyber forward, WB_LAT=6: start at cycle 0 -> first rd_en at cycle 1 with a=0, b=64, tw=1; done at cycle 491.
REQ-039 Kyber forward stage 1: pairs 0 and 32 -> (0,32,tw 2) and (64,96,tw 3).
REQ-040 Kyber inverse stage 0: pairs 0 and 1 -> (0,1,tw 320) and (2,3,tw 321).
REQ-041 Dilithium forward: done at cycle 1073; stage 7 final pair -> (254,255,tw 255).
REQ-042 Every write trails its read by 6 cycles, and no stage-s+1 read occurs before the last stage-s write.
REQ-043 rst at cycle 100 -> all outputs 0 next cycle, no further wr_en; a new start runs to completion.
REQ-044 start pulsed while busy -> ignored, and done timing is unchanged.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants and FSM state type for the NTT address generator.
package ntt_pkg;

  localparam int NW_K = 128;
  localparam int NW_D = 256;
  localparam int L_K  = 7;
  localparam int L_D  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/wb_delay.sv
// Fixed-depth register delay line that aligns bank writes with their reads.
module wb_delay #(
  parameter int W     = 17,
  parameter int DEPTH = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] pipe [DEPTH];

  // Shift register; reset wipes every stage so no stale write survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/ntt_addr_gen.sv
// Address / twiddle sequencer for an in-place NTT over a dual-operand bank.
// Handshake: start is a one-cycle request sampled only in IDLE; rd_en marks
// one butterfly pair per cycle and wr_en marks the matching writeback
// exactly WB_LAT cycles later. There is no backpressure.
module ntt_addr_gen
  import ntt_pkg::*;
#(
  parameter int WB_LAT = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       KD_mode,
  input  logic       inv,
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [8:0] tw_addr,
  output logic       wr_en,
  output logic [7:0] wr_addr_a,
  output logic [7:0] wr_addr_b,
  output logic       pe_KD_mode,
  output logic       pe_sel_1,
  output logic [3:0] stage,
  output state_t     dbg_state
);

  localparam logic [3:0] DRAIN_LAST = 4'(WB_LAT - 1);

  state_t     state_q, state_n;
  logic [6:0] pair_q, pair_n;
  logic [3:0] drain_q, drain_n;
  logic [3:0] stage_n;
  logic       kd_n, inv_n;
  logic [6:0] last_pair;
  logic [3:0] last_stage;

  logic [2:0] top_s, lg, tw_sh;
  logic [7:0] pair8, len, grp, jj, addr_a, addr_b, tw_lo;
  logic       issue_n;
  logic [16:0] wb_out;

  assign last_pair  = pe_KD_mode ? 7'd127 : 7'd63;
  assign last_stage = pe_KD_mode ? 4'd7 : 4'd6;
  assign dbg_state  = state_q;

  // Next-state logic; the registered outputs are built from the next values
  // so every output lines up with the state it belongs to.
  always_comb begin
    state_n = state_q;
    pair_n  = pair_q;
    drain_n = drain_q;
    stage_n = stage;
    kd_n    = pe_KD_mode;
    inv_n   = pe_sel_1;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          kd_n    = KD_mode;
          inv_n   = inv;
          stage_n = 4'd0;
          pair_n  = 7'd0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (pair_q == last_pair) begin
          pair_n  = 7'd0;
          drain_n = 4'd0;
          state_n = DRAIN;
        end else begin
          pair_n = pair_q + 7'd1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          drain_n = 4'd0;
          if (stage == last_stage) begin
            state_n = DONE;
          end else begin
            stage_n = stage + 4'd1;
            pair_n  = 7'd0;
            state_n = ISSUE;
          end
        end else begin
          drain_n = drain_q + 4'd1;
        end
      end
      DONE: begin
        stage_n = 4'd0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Butterfly addressing with shifts/masks: len = 2^lg, g = p >> lg,
  // j = p & (len-1), a = g*2*len + j, b = a + len (bit lg of a is clear).
  always_comb begin
    top_s   = kd_n ? 3'd7 : 3'd6;
    lg      = inv_n ? stage_n[2:0] : top_s - stage_n[2:0];
    tw_sh   = inv_n ? top_s - stage_n[2:0] : stage_n[2:0];
    pair8   = {1'b0, pair_n};
    len     = 8'd1 << lg;
    grp     = pair8 >> lg;
    jj      = pair8 & (len - 8'd1);
    addr_a  = (grp << ({1'b0, lg} + 4'd1)) | jj;
    addr_b  = addr_a | len;
    tw_lo   = (8'd1 << tw_sh) | grp;
    issue_n = (state_n == ISSUE);
  end

  // FSM state and iteration counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pair_q     <= 7'd0;
      drain_q    <= 4'd0;
      stage      <= 4'd0;
      pe_KD_mode <= 1'b0;
      pe_sel_1   <= 1'b0;
    end else begin
      state_q    <= state_n;
      pair_q     <= pair_n;
      drain_q    <= drain_n;
      stage      <= stage_n;
      pe_KD_mode <= kd_n;
      pe_sel_1   <= inv_n;
    end
  end

  // Registered read-side outputs, forced to zero outside ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= 8'd0;
      rd_addr_b <= 8'd0;
      tw_addr   <= 9'd0;
    end else begin
      busy      <= (state_n == ISSUE) || (state_n == DRAIN);
      done      <= (state_n == DONE);
      rd_en     <= issue_n;
      rd_addr_a <= issue_n ? addr_a : 8'd0;
      rd_addr_b <= issue_n ? addr_b : 8'd0;
      tw_addr   <= issue_n ? {inv_n, tw_lo} : 9'd0;
    end
  end

  wb_delay #(.W(17), .DEPTH(WB_LAT)) u_wb_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({rd_en, rd_addr_a, rd_addr_b}),
    .dout (wb_out)
  );

  assign wr_en     = wb_out[16];
  assign wr_addr_a = wb_out[15:8];
  assign wr_addr_b = wb_out[7:0];

endmodule
